dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the pipelined MIPS core: the target end of the core's M-stage load/store interface (address, store data, read/write strobes in; load data and a stall request out). Holds a word-addressed RAM, services one access at a time through a small FSM with a programmable latency, and asserts `memstall` so the hazard unit freezes the pipeline until the access completes. Optionally decodes two memory-mapped registers.

---
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the M-stage load/store port.
// Word-addressed RAM behind an IDLE/BUSY/DONE FSM with a programmable latency.
// memstall freezes the pipeline until the access completes.
// Optional feature macro: DMEM_MMIO_EN adds a cycle counter at 0xFFFF_FFF0 and an
// LED register at 0xFFFF_FFF4.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        memstall,
    output logic        misalign,
    output logic [7:0]  led
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      stateQ, stateD;
    logic [3:0]  cntQ, cntD;
    logic        request;
    logic        accept;
    logic        complete;
    logic        isLoad;
    logic        ramWe;
    logic [AW-1:0] index;
    logic [31:0] loadData;
    logic [31:0] mem [DEPTH];

    assign request = memreadM | memwriteM;
    assign accept  = (stateQ == StIdle) && request;
    // Read and write together behave as a store.
    assign isLoad  = memreadM & ~memwriteM;
    // Upper address bits are dropped so the RAM wraps.
    assign index   = aluoutM[AW+1:2];

`ifdef DMEM_MMIO_EN
    logic        hitCnt;
    logic        hitLed;
    logic [31:0] cycleQ;
    logic [7:0]  ledQ;

    assign hitCnt = (aluoutM == 32'hFFFF_FFF0);
    assign hitLed = (aluoutM == 32'hFFFF_FFF4);
    assign ramWe  = complete & memwriteM & ~(hitCnt | hitLed);
    assign led    = ledQ;

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cycleQ <= 32'd0;
        else      cycleQ <= cycleQ + 32'd1;
    end

    // LED register updated by a completed store to its address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                ledQ <= 8'd0;
        else if (complete && memwriteM && hitLed) ledQ <= writedata[7:0];
    end

    // Load source select: MMIO registers shadow the RAM at their addresses.
    always_comb begin
        loadData = mem[index];
        if (hitCnt)      loadData = cycleQ;
        else if (hitLed) loadData = {24'd0, ledQ};
    end
`else
    logic unusedAddr;

    assign unusedAddr = ^aluoutM[31:AW+2];
    assign ramWe      = complete & memwriteM;
    assign led        = 8'd0;
    assign loadData   = mem[index];
`endif

    // Next-state, latency counter and stall request.
    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        complete = 1'b0;
        memstall = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (request) begin
                    memstall = 1'b1;
                    cntD     = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        stateD   = StDone;
                        complete = 1'b1;
                    end else begin
                        stateD = StBusy;
                    end
                end
            end
            StBusy: begin
                memstall = 1'b1;
                cntD     = cntQ - 4'd1;
                // Access happens on the edge where the counter reaches zero.
                if (cntD == 4'd0) begin
                    stateD   = StDone;
                    complete = 1'b1;
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= StIdle;
            cntQ   <= 4'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // Registered load data and sticky misalignment flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readdata <= 32'd0;
            misalign <= 1'b0;
        end else begin
            if (complete && isLoad)                readdata <= loadData;
            if (accept && (aluoutM[1:0] != 2'b00)) misalign <= 1'b1;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ramWe) mem[index] <= writedata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=256, LATENCY=2).
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        memreadM;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        memstall;
    logic        misalign;
    logic [7:0]  led;

    int total;
    int bad;

    dmem_responder #(
        .DEPTH   (256),
        .LATENCY (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .memreadM  (memreadM),
        .memwriteM (memwriteM),
        .aluoutM   (aluoutM),
        .writedata (writedata),
        .readdata  (readdata),
        .memstall  (memstall),
        .misalign  (misalign),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one access just after a rising edge and holds it through DONE.
    // st[i] is memstall sampled mid-cycle in T+i; rd is readdata in T+2.
    task automatic runAccess(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, output logic [2:0] st,
                             output logic [31:0] rdOut);
        @(posedge clk);
        #1;
        memreadM  = rd;
        memwriteM = wr;
        aluoutM   = addr;
        writedata = data;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            st[i] = memstall;
            if (i == 2) rdOut = readdata;
            if (i < 2) @(posedge clk);
        end
    endtask

    task automatic goIdle();
        @(posedge clk);
        #1;
        memreadM  = 1'b0;
        memwriteM = 1'b0;
        aluoutM   = 32'd0;
        writedata = 32'd0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        memreadM  = 1'b0;
        memwriteM = 1'b0;
        aluoutM   = 32'd0;
        writedata = 32'd0;
        rst       = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (readdata !== 32'd0) begin
            bad++; $display("FAIL reset_readdata got=%h want=%h", readdata, 32'd0);
        end
        total++;
        if (memstall !== 1'b0) begin
            bad++; $display("FAIL reset_memstall got=%b want=0", memstall);
        end
        total++;
        if (misalign !== 1'b0) begin
            bad++; $display("FAIL reset_misalign got=%b want=0", misalign);
        end
        total++;
        if (led !== 8'd0) begin
            bad++; $display("FAIL reset_led got=%h want=00", led);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (memstall !== 1'b0) begin
            bad++; $display("FAIL idle_no_stall got=%b want=0", memstall);
        end
    endtask

    task automatic test_store_load();
        logic [2:0]  st;
        logic [31:0] rd;
        runAccess(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, st, rd);
        total++;
        if (st !== 3'b011) begin
            bad++; $display("FAIL store_stall got=%b want=011", st);
        end
        total++;
        if (rd !== 32'd0) begin
            bad++; $display("FAIL store_keeps_readdata got=%h want=00000000", rd);
        end
        runAccess(1'b1, 1'b0, 32'h10, 32'd0, st, rd);
        total++;
        if (st !== 3'b011) begin
            bad++; $display("FAIL load_stall got=%b want=011", st);
        end
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL load_data got=%h want=deadbeef", rd);
        end
        goIdle();
    endtask

    task automatic test_wrap();
        logic [2:0]  st;
        logic [31:0] rd;
        runAccess(1'b0, 1'b1, 32'h400, 32'h1234_5678, st, rd);
        runAccess(1'b1, 1'b0, 32'h000, 32'd0, st, rd);
        total++;
        if (rd !== 32'h1234_5678) begin
            bad++; $display("FAIL wrap_data got=%h want=12345678", rd);
        end
        goIdle();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  st1, st2;
        logic [31:0] rd1, rd2;
        runAccess(1'b0, 1'b1, 32'h4, 32'hCAFE_F00D, st1, rd1);
        goIdle();
        runAccess(1'b1, 1'b0, 32'h0, 32'd0, st1, rd1);
        runAccess(1'b1, 1'b0, 32'h4, 32'd0, st2, rd2);
        total++;
        if ({st1, st2} !== 6'b011_011) begin
            bad++; $display("FAIL b2b_stall got=%b_%b want=011_011", st1, st2);
        end
        total++;
        if (rd1 !== 32'h1234_5678) begin
            bad++; $display("FAIL b2b_first got=%h want=12345678", rd1);
        end
        total++;
        if (rd2 !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL b2b_second got=%h want=cafef00d", rd2);
        end
        goIdle();
        @(negedge clk);
        total++;
        if (memstall !== 1'b0) begin
            bad++; $display("FAIL b2b_idle_stall got=%b want=0", memstall);
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  st;
        logic [31:0] rd;
        runAccess(1'b1, 1'b0, 32'h13, 32'd0, st, rd);
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL misalign_data got=%h want=deadbeef", rd);
        end
        total++;
        if (misalign !== 1'b1) begin
            bad++; $display("FAIL misalign_set got=%b want=1", misalign);
        end
        runAccess(1'b1, 1'b0, 32'h10, 32'd0, st, rd);
        goIdle();
        @(negedge clk);
        total++;
        if (misalign !== 1'b1) begin
            bad++; $display("FAIL misalign_sticky got=%b want=1", misalign);
        end
        applyReset();
        total++;
        if (misalign !== 1'b0) begin
            bad++; $display("FAIL misalign_cleared got=%b want=0", misalign);
        end
    endtask

    task automatic test_read_write_both();
        logic [2:0]  st;
        logic [31:0] rd;
        runAccess(1'b1, 1'b1, 32'h24, 32'h1111_2222, st, rd);
        total++;
        if (rd !== 32'd0) begin
            bad++; $display("FAIL rw_readdata_held got=%h want=00000000", rd);
        end
        runAccess(1'b1, 1'b0, 32'h24, 32'd0, st, rd);
        total++;
        if (rd !== 32'h1111_2222) begin
            bad++; $display("FAIL rw_stored got=%h want=11112222", rd);
        end
        goIdle();
    endtask

    task automatic test_reset_mid_access();
        logic [2:0]  st;
        logic [31:0] rd;
        runAccess(1'b0, 1'b1, 32'h20, 32'hAAAA_0001, st, rd);
        goIdle();
        @(posedge clk);
        #1;
        memwriteM = 1'b1;
        aluoutM   = 32'h20;
        writedata = 32'hBBBB_0002;
        @(posedge clk);
        #1;
        // Now in BUSY; core and responder are reset together.
        memwriteM = 1'b0;
        aluoutM   = 32'd0;
        writedata = 32'd0;
        rst       = 1'b0;
        #2;
        total++;
        if (memstall !== 1'b0) begin
            bad++; $display("FAIL midreset_stall got=%b want=0", memstall);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        runAccess(1'b1, 1'b0, 32'h20, 32'd0, st, rd);
        total++;
        if (rd !== 32'hAAAA_0001) begin
            bad++; $display("FAIL midreset_dropped got=%h want=aaaa0001", rd);
        end
        total++;
        if (st !== 3'b011) begin
            bad++; $display("FAIL midreset_fsm_idle got=%b want=011", st);
        end
        goIdle();
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_mmio();
        logic [2:0]  st;
        logic [31:0] rd, rdA, rdB;
        runAccess(1'b0, 1'b1, 32'hFFFF_FFF4, 32'h0000_00A5, st, rd);
        total++;
        if (led !== 8'hA5) begin
            bad++; $display("FAIL mmio_led got=%h want=a5", led);
        end
        runAccess(1'b1, 1'b0, 32'hFFFF_FFF4, 32'd0, st, rd);
        total++;
        if (rd !== 32'h0000_00A5) begin
            bad++; $display("FAIL mmio_led_read got=%h want=000000a5", rd);
        end
        // Back-to-back completions are LATENCY+1 = 3 cycles apart.
        runAccess(1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0, st, rdA);
        runAccess(1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0, st, rdB);
        total++;
        if ((rdB - rdA) !== 32'd3) begin
            bad++; $display("FAIL mmio_counter_delta got=%0d want=3", rdB - rdA);
        end
        goIdle();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_store_load();
        test_wrap();
        test_back_to_back();
        test_misalign();
        test_read_write_both();
        test_reset_mid_access();
`ifdef DMEM_MMIO_EN
        test_mmio();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
